// File: rtl/mem_pkg.sv
// Shared definitions for the data memory unit: state and RW encodings plus
// default geometry.
package mem_pkg;
   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 16;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read port; contents and read
// register are never reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
      if (re) rdata <= mem_q[addr];
   end

endmodule

// File: rtl/mem_unit.sv
// Data memory behind the memory-control FSM: latches a request, waits
// WAIT_CYCLES, performs the access and holds MFC until memEN drops.
module mem_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memEN,
   input  logic              RW,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] dataIn,
   output logic [DATA_W-1:0] dataOut,
   output logic              MFC,
   output logic              busy
);

   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rw_q, rw_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              mfc_q, mfc_d;
   logic              rvalid_q, rvalid_d;
   logic              we, re;
   logic [DATA_W-1:0] rdata;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      rw_d     = rw_q;
      wdata_d  = wdata_q;
      mfc_d    = mfc_q;
      rvalid_d = rvalid_q;
      we       = 1'b0;
      re       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            mfc_d = 1'b0;
            if (memEN) begin
               addr_d  = addr;
               rw_d    = RW;
               wdata_d = dataIn;
               cnt_d   = WAIT_INIT;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!memEN) begin
               state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Access uses only the latched request fields.
               we      = (rw_q == RW_WRITE);
               re      = (rw_q == RW_READ);
               if (rw_q == RW_READ) rvalid_d = 1'b1;
               mfc_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!memEN) begin
               mfc_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            mfc_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         wdata_q  <= '0;
         mfc_q    <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         rw_q     <= rw_d;
         wdata_q  <= wdata_d;
         mfc_q    <= mfc_d;
         rvalid_q <= rvalid_d;
      end
   end

   mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
      .clk   (clk),
      .we    (we),
      .re    (re),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );

   // The RAM read register has no reset, so gate it until a read has completed.
   assign dataOut = rvalid_q ? rdata : '0;
   assign MFC     = mfc_q;
   assign busy    = (state_q == ST_BUSY) || (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit with a word-array reference model.
module tb_mem_unit;
   localparam int WAITC = 2;

   logic        clk;
   logic        rst;
   logic        mem_en, rw;
   logic [5:0]  addr;
   logic [15:0] data_in, data_out;
   logic        mfc, busy;

   logic        mem_en0, rw0;
   logic [5:0]  addr0;
   logic [15:0] data_in0, data_out0;
   logic        mfc0, busy0;

   int errors = 0;
   int checks = 0;

   logic [15:0] ref_mem [64];
   bit          ref_vld [64];
   logic [15:0] ref_dout;

   mem_unit #(.ADDR_W(6), .DATA_W(16), .WAIT_CYCLES(WAITC)) dut (
      .clk(clk), .rst(rst), .memEN(mem_en), .RW(rw), .addr(addr),
      .dataIn(data_in), .dataOut(data_out), .MFC(mfc), .busy(busy)
   );

   mem_unit #(.ADDR_W(6), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .memEN(mem_en0), .RW(rw0), .addr(addr0),
      .dataIn(data_in0), .dataOut(data_out0), .MFC(mfc0), .busy(busy0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction on the WAIT_CYCLES=2 instance.
   task automatic access(input logic r, input logic [5:0] a, input logic [15:0] d,
                         input bit churn, input int hold);
      int n;
      logic [15:0] exp;
      mem_en = 1'b1; rw = r; addr = a; data_in = d; n = 0;
      do begin
         step();
         n++;
         if (churn) begin
            addr    = a + 6'($urandom_range(1, 63));
            data_in = 16'($urandom);
            rw      = ~r;
         end
      end while (!mfc && n < 30);
      checks++;
      if (n != WAITC + 2) begin
         errors++;
         $display("FAIL latency a=%h: edges=%0d required=%0d", a, n, WAITC + 2);
      end
      if (r) begin
         exp = ref_mem[a];
         ref_dout = exp;
      end else begin
         ref_mem[a] = d;
         ref_vld[a] = 1'b1;
      end
      checks++;
      if (data_out !== ref_dout) begin
         errors++;
         $display("FAIL data_at_mfc a=%h rw=%b: got %h required %h", a, r, data_out, ref_dout);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_done: got %b required 1", busy);
      end
      for (int i = 0; i < hold; i++) begin
         step();
         if (churn) begin
            addr = 6'($urandom); data_in = 16'($urandom); rw = 1'($urandom);
         end
         checks++;
         if (mfc !== 1'b1 || data_out !== ref_dout) begin
            errors++;
            $display("FAIL hold cyc=%0d: mfc=%b data=%h required mfc=1 data=%h", i, mfc, data_out, ref_dout);
         end
      end
      mem_en = 1'b0;
      step();
      checks++;
      if (mfc !== 1'b0 || busy !== 1'b0 || data_out !== ref_dout) begin
         errors++;
         $display("FAIL release: mfc=%b busy=%b data=%h required mfc=0 busy=0 data=%h",
                  mfc, busy, data_out, ref_dout);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_en = 0; rw = 0; addr = 0; data_in = 0;
      mem_en0 = 0; rw0 = 0; addr0 = 0; data_in0 = 0;
      ref_dout = 16'h0000;
      #2 rst = 1'b0;
      #2;
      checks++;
      if (mfc !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0000) begin
         errors++;
         $display("FAIL reset: mfc=%b busy=%b data=%h required 0 0 0000", mfc, busy, data_out);
      end
      checks++;
      if (mfc0 !== 1'b0 || busy0 !== 1'b0 || data_out0 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_w0: mfc=%b busy=%b data=%h required 0 0 0000", mfc0, busy0, data_out0);
      end
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_write_read();
      access(1'b0, 6'h05, 16'hBEEF, 1'b0, 0);
      access(1'b1, 6'h05, 16'h0000, 1'b0, 0);
   endtask

   task automatic test_abort();
      access(1'b0, 6'h3F, 16'h0000, 1'b0, 0);
      mem_en = 1'b1; rw = 1'b0; addr = 6'h3F; data_in = 16'h1234;
      step();
      step();
      mem_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mfc !== 1'b0 || data_out !== ref_dout) begin
            errors++;
            $display("FAIL abort cyc=%0d: mfc=%b data=%h required mfc=0 data=%h", i, mfc, data_out, ref_dout);
         end
         step();
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy: got %b required 0", busy);
      end
      access(1'b1, 6'h3F, 16'h0000, 1'b0, 0);
   endtask

   task automatic test_churn();
      access(1'b0, 6'h01, 16'hA5A5, 1'b0, 0);
      access(1'b0, 6'h02, 16'h5A5A, 1'b0, 0);
      access(1'b1, 6'h01, 16'h0000, 1'b1, 0);
   endtask

   task automatic test_hold();
      access(1'b1, 6'h05, 16'h0000, 1'b1, 10);
   endtask

   task automatic test_wait0();
      int n;
      for (int k = 0; k < 2; k++) begin
         mem_en0 = 1'b1; rw0 = (k == 1); addr0 = 6'h2A; data_in0 = 16'hC3D2; n = 0;
         do begin
            step();
            n++;
         end while (!mfc0 && n < 30);
         checks++;
         if (n != 2) begin
            errors++;
            $display("FAIL latency_w0 k=%0d: edges=%0d required 2", k, n);
         end
         if (k == 1) begin
            checks++;
            if (data_out0 !== 16'hC3D2) begin
               errors++;
               $display("FAIL read_w0: got %h required c3d2", data_out0);
            end
         end
         mem_en0 = 1'b0;
         step();
      end
   endtask

   task automatic test_async_reset();
      int n;
      mem_en = 1'b1; rw = 1'b1; addr = 6'h05; n = 0;
      do begin
         step();
         n++;
      end while (!mfc && n < 30);
      checks++;
      if (mfc !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: mfc=%b required 1", mfc);
      end
      #3 rst = 1'b0;
      #1;
      ref_dout = 16'h0000;
      checks++;
      if (mfc !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0000) begin
         errors++;
         $display("FAIL async_reset: mfc=%b busy=%b data=%h required 0 0 0000", mfc, busy, data_out);
      end
      mem_en = 1'b0;
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_reset_mid_write();
      access(1'b0, 6'h07, 16'h5555, 1'b0, 0);
      mem_en = 1'b1; rw = 1'b0; addr = 6'h07; data_in = 16'hAAAA;
      step();
      step();
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      mem_en = 1'b0;
      ref_dout = 16'h0000;
      step();
      checks++;
      if (mfc !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_write: mfc=%b busy=%b required 0 0", mfc, busy);
      end
      access(1'b1, 6'h07, 16'h0000, 1'b0, 0);
   endtask

   task automatic test_random();
      logic [5:0] a;
      for (int i = 0; i < 40; i++) begin
         a = 6'($urandom_range(0, 15));
         if (($urandom % 2 == 1) && ref_vld[a])
            access(1'b1, a, 16'h0000, 1'($urandom), int'($urandom_range(0, 3)));
         else
            access(1'b0, a, 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         ref_vld[i] = 1'b0;
         ref_mem[i] = 16'h0000;
      end
      test_reset();
      test_write_read();
      test_abort();
      test_churn();
      test_hold();
      test_wait0();
      test_async_reset();
      test_reset_mid_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
